// File: rtl/data_cache_if.sv
// Core data port and 128-bit memory port of the data cache, bundled as one interface.
interface data_cache_if;
  logic [31:0]  dcache_addr;
  logic         dcache_re;
  logic [3:0]   dcache_we;
  logic [31:0]  dcache_din;
  logic [31:0]  dcache_dout;
  logic         stall;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic [15:0]  mem_req_mask;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  // Core plus memory side.
  modport master (
    output dcache_addr, dcache_re, dcache_we, dcache_din,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  dcache_dout, stall,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask
  );

  // Cache side.
  modport slave (
    input  dcache_addr, dcache_re, dcache_we, dcache_din,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output dcache_dout, stall,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with single-beat line refill.
module data_cache #(
  parameter int unsigned LINES = 16
) (
  input logic         clk,
  input logic         reset,
  data_cache_if.slave bus
);
  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 28 - IW;

  typedef enum logic [2:0] {
    IDLE, LOOKUP_RD, WRITE, READ_REQ, READ_WAIT, RESP
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [127:0]     line_q [LINES];

  logic         stall_q, req_valid_q, req_rw_q;
  logic [31:0]  dout_q;
  logic [27:0]  req_line_q;
  logic [1:0]   req_word_q;
  logic [15:0]  req_mask_q;
  logic [127:0] req_data_q;

  logic          accept_c, refill_c, store_c, hit_c;
  logic [IW-1:0] idx_c, req_idx_c;
  logic [TW-1:0] tag_c;
  logic [1:0]    word_c;
  logic [15:0]   mask_c;
  logic [127:0]  din_rep_c;
  logic          unused_addr_c;

  assign idx_c         = bus.dcache_addr[3+IW:4];
  assign tag_c         = bus.dcache_addr[31:4+IW];
  assign word_c        = bus.dcache_addr[3:2];
  assign store_c       = |bus.dcache_we;
  assign hit_c         = valid_q[idx_c] && (tag_q[idx_c] == tag_c);
  assign mask_c        = 16'(bus.dcache_we) << {word_c, 2'b00};
  assign din_rep_c     = {4{bus.dcache_din}};
  assign req_idx_c     = req_line_q[IW-1:0];
  assign unused_addr_c = ^bus.dcache_addr[1:0];

  // Next-state logic; IDLE, LOOKUP_RD and RESP all accept a new request, stores win over loads.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    refill_c = 1'b0;
    case (state_q)
      IDLE, LOOKUP_RD, RESP: begin
        if (store_c) begin
          accept_c = 1'b1;
          state_d  = WRITE;
        end else if (bus.dcache_re) begin
          accept_c = 1'b1;
          state_d  = hit_c ? LOOKUP_RD : READ_REQ;
        end else begin
          state_d  = IDLE;
        end
      end
      WRITE:     if (bus.mem_req_ready) state_d = IDLE;
      READ_REQ:  if (bus.mem_req_ready) state_d = READ_WAIT;
      READ_WAIT: begin
        if (bus.mem_resp_valid) begin
          refill_c = 1'b1;
          state_d  = RESP;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  // Control and request registers; reset aborts any transaction immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      stall_q     <= 1'b0;
      req_valid_q <= 1'b0;
      dout_q      <= '0;
      valid_q     <= '0;
      req_rw_q    <= 1'b0;
      req_line_q  <= '0;
      req_word_q  <= '0;
      req_mask_q  <= '0;
      req_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      stall_q     <= (state_d == WRITE) || (state_d == READ_REQ) || (state_d == READ_WAIT);
      req_valid_q <= (state_d == WRITE) || (state_d == READ_REQ);
      if (accept_c) begin
        req_rw_q   <= store_c;
        req_line_q <= bus.dcache_addr[31:4];
        req_word_q <= word_c;
        req_mask_q <= mask_c;
        req_data_q <= din_rep_c;
      end
      if (accept_c && !store_c && hit_c)
        dout_q <= line_q[idx_c][{word_c, 5'd0} +: 32];
      if (refill_c) begin
        dout_q             <= bus.mem_resp_data[{req_word_q, 5'd0} +: 32];
        valid_q[req_idx_c] <= 1'b1;
      end
    end
  end

  // Tag and data storage: store-hit byte merge on acceptance, full-line write on refill.
  always_ff @(posedge clk) begin
    if (accept_c && store_c && hit_c) begin
      for (int b = 0; b < 16; b++)
        if (mask_c[b]) line_q[idx_c][8*b +: 8] <= din_rep_c[8*b +: 8];
    end
    if (refill_c) begin
      line_q[req_idx_c] <= bus.mem_resp_data;
      tag_q[req_idx_c]  <= req_line_q[27:IW];
    end
  end

  assign bus.dcache_dout   = dout_q;
  assign bus.stall         = stall_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_rw    = req_rw_q;
  assign bus.mem_req_addr  = req_line_q;
  assign bus.mem_req_data  = req_data_q;
  assign bus.mem_req_mask  = req_mask_q;
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: loads, stores, refill conflicts, ready back-pressure, mid-miss reset.
module tb_data_cache;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  data_cache_if bus ();

  data_cache #(.LINES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load expected to hit: no stall, data in the cycle after acceptance.
  task automatic load_hit(input logic [31:0] a, input logic [31:0] exp);
    bus.dcache_re   = 1'b1;
    bus.dcache_addr = a;
    @(negedge clk);
    bus.dcache_re = 1'b0;
    check("hit_stall", 128'(bus.stall), 128'd0);
    check("hit_req_valid", 128'(bus.mem_req_valid), 128'd0);
    check("hit_dout", 128'(bus.dcache_dout), 128'(exp));
  endtask

  // Load expected to miss: ready after rdly stalled cycles, response sdly edges after ready.
  task automatic load_miss(input logic [31:0] a, input logic [127:0] line,
                           input int rdly, input int sdly, input logic [31:0] exp);
    bus.dcache_re   = 1'b1;
    bus.dcache_addr = a;
    @(negedge clk);
    bus.dcache_re = 1'b0;
    check("miss_stall", 128'(bus.stall), 128'd1);
    check("miss_req_valid", 128'(bus.mem_req_valid), 128'd1);
    repeat (rdly) begin
      @(negedge clk);
      check("hold_req_valid", 128'(bus.mem_req_valid), 128'd1);
      check("hold_req_addr", 128'(bus.mem_req_addr), 128'(a[31:4]));
      check("hold_stall", 128'(bus.stall), 128'd1);
    end
    check("rd_rw", 128'(bus.mem_req_rw), 128'd0);
    check("rd_addr", 128'(bus.mem_req_addr), 128'(a[31:4]));
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    repeat (sdly - 1) begin
      check("wait_stall", 128'(bus.stall), 128'd1);
      check("wait_req_valid", 128'(bus.mem_req_valid), 128'd0);
      @(negedge clk);
    end
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = line;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("miss_stall_low", 128'(bus.stall), 128'd0);
    check("miss_dout", 128'(bus.dcache_dout), 128'(exp));
  endtask

  // Store with ready held high: one write handshake, one stall cycle.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                       input logic [15:0] exp_mask);
    bus.dcache_we   = we;
    bus.dcache_din  = d;
    bus.dcache_addr = a;
    @(negedge clk);
    bus.dcache_we = 4'd0;
    check("st_stall", 128'(bus.stall), 128'd1);
    check("st_req_valid", 128'(bus.mem_req_valid), 128'd1);
    check("st_rw", 128'(bus.mem_req_rw), 128'd1);
    check("st_addr", 128'(bus.mem_req_addr), 128'(a[31:4]));
    check("st_mask", 128'(bus.mem_req_mask), 128'(exp_mask));
    check("st_data", bus.mem_req_data, {4{d}});
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check("st_stall_low", 128'(bus.stall), 128'd0);
    check("st_req_valid_low", 128'(bus.mem_req_valid), 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset              = 1'b0;
    bus.dcache_addr    = '0;
    bus.dcache_re      = 1'b0;
    bus.dcache_we      = 4'd0;
    bus.dcache_din     = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_stall", 128'(bus.stall), 128'd0);
    check("rst_req_valid", 128'(bus.mem_req_valid), 128'd0);
    check("rst_dout", 128'(bus.dcache_dout), 128'd0);

    // Refill and hit on the same line.
    load_miss(32'h0000_1004, 128'h00000044_00000033_00000022_00000011, 0, 3, 32'h22);
    load_hit(32'h0000_1008, 32'h33);

    // Store hit merges low two bytes; store miss does not allocate.
    store(32'h0000_1008, 32'hAABB_CCDD, 4'b0011, 16'h0300);
    load_hit(32'h0000_1008, 32'h0000_CCDD);
    store(32'h0000_2000, 32'h1234_5678, 4'b1111, 16'h000F);
    load_miss(32'h0000_2000, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 0, 1, 32'hA0A0_A0A0);

    // Same index, different tags: three refills.
    load_miss(32'h0000_1000, 128'h5A5A5A53_5A5A5A52_5A5A5A51_5A5A5A50, 1, 2, 32'h5A5A_5A50);
    load_miss(32'h0000_1100, 128'h6B6B6B63_6B6B6B62_6B6B6B61_6B6B6B60, 0, 2, 32'h6B6B_6B60);
    load_miss(32'h0000_1000, 128'h7C7C7C73_7C7C7C72_7C7C7C71_7C7C7C70, 0, 1, 32'h7C7C_7C70);

    // Ready held low for 10 cycles, then back-to-back hits out of RESP.
    load_miss(32'h0000_3014, 128'h33333333_22222222_11111111_00000000, 10, 2, 32'h1111_1111);
    load_hit(32'h0000_3018, 32'h2222_2222);
    load_hit(32'h0000_301C, 32'h3333_3333);

    // Reset pulse during READ_WAIT aborts the miss; late response is ignored.
    bus.dcache_re   = 1'b1;
    bus.dcache_addr = 32'h0000_4008;
    @(negedge clk);
    bus.dcache_re     = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check("rw_wait_stall", 128'(bus.stall), 128'd1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_stall", 128'(bus.stall), 128'd0);
    check("async_rst_req_valid", 128'(bus.mem_req_valid), 128'd0);
    @(negedge clk);
    reset              = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("late_resp_stall", 128'(bus.stall), 128'd0);
    check("late_resp_dout", 128'(bus.dcache_dout), 128'd0);
    load_miss(32'h0000_4008, 128'h44444443_44444442_44444441_44444440, 0, 1, 32'h4444_4442);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
